torpedo_fire_ctrl: RTL and testbench

- Initiator side of the torpedo fire protocol: debounces the raw fire button on frame boundaries, fetches the launch sin/cos for the current ship angle, and issues a one-cycle launch pulse to the lowest free torpedo slot.
- Sits between the ship/input logic and an array of torpedo units.
- Enforces a per-shot frame cooldown and a release-before-refire rule.

---
 rtl/torpedo_pkg.sv | 27 ++
 rtl/fire_debounce.sv | 37 +++
 rtl/torpedo_fire_ctrl.sv | 163 ++++++++++++++++
 tb/tb_torpedo_fire_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/torpedo_pkg.sv
// -----------------------------------------------------------------------------
// torpedo_pkg
// Shared definitions for the torpedo fire controller:
//   fire_state_t : controller FSM states
//   TRIG_W       : width of the signed trig ROM sine/cosine words
//   MAX_SLOTS    : upper bound on the number of torpedo slots
//   lowest_free  : isolates the lowest set bit of a slot mask (one-hot result)
// -----------------------------------------------------------------------------
package torpedo_pkg;

   localparam int TRIG_W    = 18;
   localparam int MAX_SLOTS = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FETCH    = 3'd1,
      SELECT   = 3'd2,
      COOLDOWN = 3'd3,
      RELEASE  = 3'd4
   } fire_state_t;

   // mask & -mask keeps only the lowest set bit; an empty mask yields zero.
   function automatic logic [MAX_SLOTS-1:0] lowest_free(input logic [MAX_SLOTS-1:0] mask);
      return mask & (~mask + MAX_SLOTS'(1));
   endfunction

endpackage

// File: rtl/fire_debounce.sv
// -----------------------------------------------------------------------------
// fire_debounce
// Frame-based debouncer for the raw fire button. A test flag is armed on every
// vsync and cleared by any low sample of the button in the following frame;
// the next vsync transfers it to deb. deb is therefore high only when the
// button was held on every non-vsync cycle of the previous frame.
// Ports:
//   clk, resetN : clock, asynchronous active-low reset
//   vsync       : one-cycle frame pulse
//   btn         : raw button level, active-high
//   deb         : debounced button level, changes only on vsync
// -----------------------------------------------------------------------------
module fire_debounce (
   input  logic clk,
   input  logic resetN,
   input  logic vsync,
   input  logic btn,
   output logic deb
);

   logic test;

   // NOTE: sequential state uses non-blocking assignments so deb samples the
   // pre-edge value of test while test is re-armed on the same vsync edge.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         test <= 1'b0;
         deb  <= 1'b0;
      end else if (vsync) begin
         deb  <= test;
         test <= 1'b1;
      end else begin
         test <= test & btn;
      end
   end

endmodule

// File: rtl/torpedo_fire_ctrl.sv
// -----------------------------------------------------------------------------
// torpedo_fire_ctrl
// Initiator side of the torpedo fire protocol. A debounced press fetches the
// launch sin/cos for the current ship angle from the trig ROM, then fires a
// one-cycle one-hot launch pulse into the lowest free torpedo slot. A frame
// cooldown and a release-before-refire rule limit the fire rate.
//
// Optional build macro: TORPEDO_AUTOFIRE_EN
//   defined   : holding the button re-fires every COOLDOWN_FRAMES frames
//   undefined : one shot per press, the button must be released in between
//
// Ports:
//   clk, resetN  : clock, asynchronous active-low reset
//   vsync        : one-cycle frame pulse
//   fire_btn     : raw fire button level
//   angle_in     : current ship angle index (0..359)
//   sin_in/cos_in: trig ROM outputs, valid TRIG_LAT cycles after trig_addr is
//                  issued (the trig_addr register counts as the first cycle)
//   slot_busy    : per-slot "torpedo flying" level
//   slot_dead    : per-slot one-cycle death pulse (slot counts as free)
//   trig_addr    : trig ROM address, latched at the start of a fetch
//   launch       : one-hot, one-cycle launch pulse
//   sin_out/cos_out : launch direction, valid with launch, held until the
//                  next fetch completes
//   fire_deb     : debounced button
//   shot_dropped : one-cycle pulse when a shot finds every slot occupied
//   ready        : high while idle
// -----------------------------------------------------------------------------
module torpedo_fire_ctrl
   import torpedo_pkg::*;
#(
   parameter int TORPEDOS        = 4,
   parameter int ANGLE_W         = 9,
   parameter int TRIG_LAT        = 2,
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic                     clk,
   input  logic                     resetN,
   input  logic                     vsync,
   input  logic                     fire_btn,
   input  logic [ANGLE_W-1:0]       angle_in,
   input  logic signed [TRIG_W-1:0] sin_in,
   input  logic signed [TRIG_W-1:0] cos_in,
   input  logic [TORPEDOS-1:0]      slot_busy,
   input  logic [TORPEDOS-1:0]      slot_dead,
   output logic [ANGLE_W-1:0]       trig_addr,
   output logic [TORPEDOS-1:0]      launch,
   output logic signed [TRIG_W-1:0] sin_out,
   output logic signed [TRIG_W-1:0] cos_out,
   output logic                     fire_deb,
   output logic                     shot_dropped,
   output logic                     ready
);

   localparam int LAT_W = 3;                              // TRIG_LAT <= 4
   localparam int CD_W  = $clog2(COOLDOWN_FRAMES + 1);

   fire_state_t                state;
   logic                       fire_deb_q;
   logic                       press;
   logic [LAT_W-1:0]           lat_cnt;
   logic                       lat_done;
   logic [CD_W-1:0]            cd_cnt;
   logic [TORPEDOS-1:0]        free_mask;
   logic [MAX_SLOTS-1:0]       pick_ext;
   logic [TORPEDOS-1:0]        pick;
   logic                       any_free;

   fire_debounce u_debounce (
      .clk    (clk),
      .resetN (resetN),
      .vsync  (vsync),
      .btn    (fire_btn),
      .deb    (fire_deb)
   );

   assign press     = fire_deb & ~fire_deb_q;
   assign lat_done  = (lat_cnt + LAT_W'(1)) == LAT_W'(TRIG_LAT);

   // A slot whose torpedo dies this very cycle is reusable immediately.
   assign free_mask = ~slot_busy | slot_dead;
   assign pick_ext  = lowest_free(MAX_SLOTS'(free_mask));
   assign pick      = pick_ext[TORPEDOS-1:0];
   assign any_free  = |pick_ext;

   assign ready     = (state == IDLE);

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state        <= IDLE;
         fire_deb_q   <= 1'b0;
         trig_addr    <= '0;
         lat_cnt      <= '0;
         cd_cnt       <= '0;
         sin_out      <= '0;
         cos_out      <= '0;
         launch       <= '0;
         shot_dropped <= 1'b0;
      end else begin
         fire_deb_q   <= fire_deb;
         // Pulses fall back to zero unless re-asserted below.
         launch       <= '0;
         shot_dropped <= 1'b0;

         case (state)
            IDLE: begin
               if (press) begin
                  trig_addr <= angle_in;
                  lat_cnt   <= '0;
                  state     <= FETCH;
               end
            end

            FETCH: begin
               lat_cnt <= lat_cnt + LAT_W'(1);
               if (lat_done) begin
                  sin_out <= sin_in;
                  cos_out <= cos_in;
                  state   <= SELECT;
               end
            end

            SELECT: begin
               if (any_free) begin
                  launch <= pick;
                  cd_cnt <= CD_W'(COOLDOWN_FRAMES);
                  state  <= COOLDOWN;
               end else begin
                  shot_dropped <= 1'b1;
                  state        <= RELEASE;
               end
            end

            COOLDOWN: begin
               if (cd_cnt == '0) begin
`ifdef TORPEDO_AUTOFIRE_EN
                  if (fire_deb) begin
                     trig_addr <= angle_in;
                     lat_cnt   <= '0;
                     state     <= FETCH;
                  end else begin
                     state <= IDLE;
                  end
`else
                  state <= RELEASE;
`endif
               end else if (vsync) begin
                  cd_cnt <= cd_cnt - CD_W'(1);
               end
            end

            RELEASE: begin
               if (!fire_deb) begin
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_torpedo_fire_ctrl.sv
// -----------------------------------------------------------------------------
// tb_torpedo_fire_ctrl
// Self-checking bench for torpedo_fire_ctrl (default parameters). A table of
// slot-occupancy vectors is applied in a loop; expected launches go into a
// scoreboard queue that a negedge monitor drains as launches appear. Extra
// hand-written sequences cover the glitch filter, a long hold, and reset in
// the middle of a fetch. The trig ROM is modelled with TRIG_LAT-1 pipeline
// stages behind the trig_addr register.
// -----------------------------------------------------------------------------
module tb_torpedo_fire_ctrl;

   localparam int TORPEDOS        = 4;
   localparam int ANGLE_W         = 9;
   localparam int TRIG_LAT        = 2;
   localparam int COOLDOWN_FRAMES = 8;
   localparam int FRAME           = 128;

   typedef struct {
      logic [3:0] busy;
      logic [3:0] dead;
      logic [8:0] angle;
      logic [3:0] exp_launch;
      logic       exp_drop;
   } vec_t;

   typedef struct {
      logic [3:0]         launch;
      logic signed [17:0] s;
      logic signed [17:0] c;
      logic               chk_lat;
   } exp_t;

   logic                clk = 1'b0;
   logic                resetN = 1'b0;
   logic                vsync = 1'b0;
   logic                fire_btn = 1'b0;
   logic [ANGLE_W-1:0]  angle_in = '0;
   logic signed [17:0]  sin_in = '0;
   logic signed [17:0]  cos_in = '0;
   logic [TORPEDOS-1:0] slot_busy = '0;
   logic [TORPEDOS-1:0] slot_dead = '0;
   logic [ANGLE_W-1:0]  trig_addr;
   logic [TORPEDOS-1:0] launch;
   logic signed [17:0]  sin_out;
   logic signed [17:0]  cos_out;
   logic                fire_deb;
   logic                shot_dropped;
   logic                ready;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc = 0, rise_cyc = -1000;
   int   vs_cnt = 0, deb_hi_cnt = 0, drop_cnt = 0, launch_cnt = 0;
   logic test_m = 1'b0, deb_m = 1'b0;
   logic auto_mode = 1'b0, auto_seen = 1'b0;
   int   last_vs = 0;
   exp_t sb[$];
   logic [8:0] hist [4] = '{default: '0};

   torpedo_fire_ctrl #(
      .TORPEDOS        (TORPEDOS),
      .ANGLE_W         (ANGLE_W),
      .TRIG_LAT        (TRIG_LAT),
      .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .vsync        (vsync),
      .fire_btn     (fire_btn),
      .angle_in     (angle_in),
      .sin_in       (sin_in),
      .cos_in       (cos_in),
      .slot_busy    (slot_busy),
      .slot_dead    (slot_dead),
      .trig_addr    (trig_addr),
      .launch       (launch),
      .sin_out      (sin_out),
      .cos_out      (cos_out),
      .fire_deb     (fire_deb),
      .shot_dropped (shot_dropped),
      .ready        (ready)
   );

   initial forever #5 clk = ~clk;

   function automatic logic signed [17:0] rom_sin(input logic [8:0] a);
      return 18'(32'(a) * 517 + 1001);
   endfunction

   function automatic logic signed [17:0] rom_cos(input logic [8:0] a);
      return 18'(130000 - 32'(a) * 211);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Frame generator: vsync high for one cycle every FRAME cycles.
   initial begin
      int fc;
      fc = 0;
      forever begin
         @(posedge clk);
         #1;
         fc    = (fc == FRAME - 1) ? 0 : fc + 1;
         vsync = (fc == FRAME - 1);
      end
   end

   // Reference debouncer and cycle counter, evaluated on the active edge.
   initial begin
      forever begin
         @(posedge clk or negedge resetN);
         if (!resetN) begin
            test_m = 1'b0;
            deb_m  = 1'b0;
         end else begin
            cyc++;
            if (vsync) begin
               if (test_m && !deb_m) rise_cyc = cyc;
               deb_m  = test_m;
               test_m = 1'b1;
            end else begin
               test_m = test_m & fire_btn;
            end
         end
      end
   end

   // Trig ROM model.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = trig_addr;
         sin_in  = rom_sin(hist[TRIG_LAT-1]);
         cos_in  = rom_cos(hist[TRIG_LAT-1]);
      end
   end

   // Output monitor / scoreboard consumer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetN) begin
            if (vsync)        vs_cnt++;
            if (fire_deb)     deb_hi_cnt++;
            if (shot_dropped) drop_cnt++;
            if (launch != '0) begin
               launch_cnt++;
`ifdef TORPEDO_AUTOFIRE_EN
               if (auto_mode) begin
                  if (auto_seen) check("auto_spacing", vs_cnt - last_vs, COOLDOWN_FRAMES);
                  auto_seen = 1'b1;
                  last_vs   = vs_cnt;
                  check("auto_slot", launch, 4'b0001);
               end else
`endif
               if (sb.size() == 0) begin
                  check("unexpected_launch", launch, 0);
               end else begin
                  e = sb.pop_front();
                  check("launch_slot", launch, e.launch);
                  check("launch_sin", sin_out, e.s);
                  check("launch_cos", cos_out, e.c);
                  if (e.chk_lat) check("launch_latency", cyc - rise_cyc, TRIG_LAT + 2);
               end
            end
         end
      end
   end

   task automatic wait_deb_rise(input int max);
      for (int i = 0; i < max && fire_deb !== 1'b1; i++) step(1);
      check("fire_deb_rise", fire_deb, 1);
      check("fire_deb_timing", cyc, rise_cyc);
   endtask

   task automatic wait_ready(input int max);
      for (int i = 0; i < max && ready !== 1'b1; i++) step(1);
      check("ready_return", ready, 1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int l0, d0;
      angle_in  = v.angle;
      slot_busy = v.busy;
      l0 = launch_cnt;
      d0 = drop_cnt;
      if (v.exp_launch != '0) sb.push_back('{v.exp_launch, rom_sin(v.angle), rom_cos(v.angle), 1'b1});
      fire_btn = 1'b1;
      wait_deb_rise(3 * FRAME);                      // press cycle
      step(1);                                       // first FETCH cycle
      angle_in = 9'((32'(v.angle) + 123) % 360);     // must not disturb the fetch
      step(2);                                       // SELECT cycle
      slot_dead = v.dead;
      step(1);
      slot_dead = '0;
      step(2);
      check($sformatf("v%0d_trig_addr", idx), trig_addr, v.angle);
      check($sformatf("v%0d_launch_count", idx), launch_cnt - l0, (v.exp_launch != '0));
      check($sformatf("v%0d_drop_count", idx), drop_cnt - d0, v.exp_drop);
      fire_btn = 1'b0;
      wait_ready(14 * FRAME);
      slot_busy = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[7];
      int   l0, d0;
      vecs[0] = '{4'b0000, 4'b0000, 9'd90,  4'b0001, 1'b0};
      vecs[1] = '{4'b0011, 4'b0000, 9'd45,  4'b0100, 1'b0};
      vecs[2] = '{4'b1111, 4'b0000, 9'd10,  4'b0000, 1'b1};
      vecs[3] = '{4'b1111, 4'b0010, 9'd135, 4'b0010, 1'b0};
      vecs[4] = '{4'b0111, 4'b0000, 9'd270, 4'b1000, 1'b0};
      vecs[5] = '{4'b1110, 4'b0000, 9'd1,   4'b0001, 1'b0};
      vecs[6] = '{4'b1011, 4'b1000, 9'd300, 4'b0100, 1'b0};

      // Reset state.
      step(3);
      resetN = 1'b1;
      check("rst_launch",    launch, 0);
      check("rst_sin",       sin_out, 0);
      check("rst_cos",       cos_out, 0);
      check("rst_trig_addr", trig_addr, 0);
      check("rst_fire_deb",  fire_deb, 0);
      check("rst_drop",      shot_dropped, 0);
      check("rst_ready",     ready, 1);

      // Short glitch inside one frame never reaches fire_deb.
      for (int i = 0; i < 2 * FRAME && vsync !== 1'b1; i++) step(1);
      step(10);
      l0 = launch_cnt;
      d0 = deb_hi_cnt;
      fire_btn = 1'b1;
      step(100);
      fire_btn = 1'b0;
      step(3 * FRAME);
      check("glitch_deb_cycles", deb_hi_cnt - d0, 0);
      check("glitch_launches",   launch_cnt - l0, 0);

      // Slot-selection table.
      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Button held for 30 frames.
      angle_in  = 9'd200;
      slot_busy = '0;
      l0 = launch_cnt;
`ifdef TORPEDO_AUTOFIRE_EN
      auto_mode = 1'b1;
      auto_seen = 1'b0;
`else
      sb.push_back('{4'b0001, rom_sin(9'd200), rom_cos(9'd200), 1'b1});
`endif
      fire_btn = 1'b1;
      step(30 * FRAME);
`ifdef TORPEDO_AUTOFIRE_EN
      check("held_auto_launches", (launch_cnt - l0) >= 3, 1);
`else
      check("held_launch_count", launch_cnt - l0, 1);
      check("held_waits_release", ready, 0);
`endif
      fire_btn = 1'b0;
      wait_ready(14 * FRAME);
      auto_mode = 1'b0;

      // Reset asserted during FETCH aborts the shot.
      angle_in = 9'd77;
      l0 = launch_cnt;
      fire_btn = 1'b1;
      wait_deb_rise(3 * FRAME);
      step(1);
      resetN = 1'b0;
      step(2);
      resetN = 1'b1;
      check("midrst_launch",    launch, 0);
      check("midrst_sin",       sin_out, 0);
      check("midrst_cos",       cos_out, 0);
      check("midrst_trig_addr", trig_addr, 0);
      check("midrst_fire_deb",  fire_deb, 0);
      check("midrst_drop",      shot_dropped, 0);
      check("midrst_ready",     ready, 1);
      check("midrst_no_launch", launch_cnt - l0, 0);
      sb.push_back('{4'b0001, rom_sin(9'd77), rom_cos(9'd77), 1'b1});
      wait_deb_rise(3 * FRAME);
      step(6);
      check("post_reset_launch", launch_cnt - l0, 1);
      fire_btn = 1'b0;
      wait_ready(14 * FRAME);

      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
